// File: rtl/ahb_waterlight_gen_if.sv
// AHB-Lite slave-side bus bundle for the running-light peripheral.
`timescale 1ns/1ps
interface ahb_waterlight_gen_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_waterlight_gen.sv
// AHB-Lite zero-wait-state slave producing an autonomous running-light pattern
// with programmable mode, prescaler reload, seed pattern and a step counter.
`timescale 1ns/1ps
module ahb_waterlight_gen #(
  parameter int unsigned      LED_W    = 8,
  parameter int unsigned      SPEED_W  = 32,
  parameter logic [LED_W-1:0] LED_INIT = LED_W'(1)
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_waterlight_gen_if.slave bus,
  output logic [LED_W-1:0]   led
);

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SPEED = 2'd1;
  localparam logic [1:0] REG_PAT   = 2'd2;
  localparam logic [1:0] REG_STEP  = 2'd3;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_ROTL  = 2'd1,
    MODE_ROTR  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  logic [1:0]         addr_q;
  logic               wr_q;
  logic               rd_old_q;
  logic [31:0]        old_q;
  mode_e              mode_q;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] cnt_q;
  logic [15:0]        step_q;

  logic               accept_c;
  logic               commit_c;
  logic               wr_ctrl_c;
  logic               wr_speed_c;
  logic               wr_pat_c;
  logic               wr_step_c;
  logic               tick_c;
  logic               hazard_c;
  logic [LED_W-1:0]   led_next_c;
  logic [31:0]        rdata_c;
  logic               unused_c;

  // Bus decode, prescaler tick and read-after-write hazard detection
  always_comb begin
    accept_c   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    commit_c   = wr_q & bus.HREADY;
    wr_ctrl_c  = commit_c && (addr_q == REG_CTRL);
    wr_speed_c = commit_c && (addr_q == REG_SPEED);
    wr_pat_c   = commit_c && (addr_q == REG_PAT);
    wr_step_c  = commit_c && (addr_q == REG_STEP);
    tick_c     = (mode_q != MODE_HOLD) && (cnt_q == speed_q) && !(wr_ctrl_c || wr_speed_c);
    // A read issued under a committing write to the same register sees the pre-write value
    hazard_c   = accept_c && !bus.HWRITE && commit_c && (bus.HADDR[3:2] == addr_q);
  end

  // Next pattern; an empty rotate reseeds so a light is always running
  always_comb begin
    led_next_c = led;
    case (mode_q)
      MODE_ROTL:  led_next_c = (led == '0) ? LED_W'(1)
                                           : {led[LED_W-2:0], led[LED_W-1]};
      MODE_ROTR:  led_next_c = (led == '0) ? {1'b1, {(LED_W-1){1'b0}}}
                                           : {led[0], led[LED_W-1:1]};
      MODE_BLINK: led_next_c = ~led;
      default:    led_next_c = led;
    endcase
  end

  always_comb begin
    rdata_c = 32'd0;
    case (addr_q)
      REG_CTRL:  rdata_c = 32'(mode_q);
      REG_SPEED: rdata_c = 32'(speed_q);
      REG_PAT:   rdata_c = 32'(led);
      REG_STEP:  rdata_c = 32'(step_q);
      default:   rdata_c = 32'd0;
    endcase
  end

  assign bus.HRDATA    = rd_old_q ? old_q : rdata_c;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign unused_c      = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HSIZE, bus.HPROT, bus.HWDATA};

  // Address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= REG_CTRL;
      wr_q     <= 1'b0;
      rd_old_q <= 1'b0;
      old_q    <= 32'd0;
    end else begin
      if (accept_c) addr_q <= bus.HADDR[3:2];
      wr_q     <= accept_c & bus.HWRITE;
      rd_old_q <= hazard_c;
      if (hazard_c) old_q <= rdata_c;
    end
  end

  // Control registers, prescaler, pattern and step counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q  <= MODE_HOLD;
      speed_q <= '0;
      cnt_q   <= '0;
      led     <= LED_INIT;
      step_q  <= 16'd0;
    end else begin
      if (wr_ctrl_c)  mode_q  <= mode_e'(bus.HWDATA[1:0]);
      if (wr_speed_c) speed_q <= bus.HWDATA[SPEED_W-1:0];

      if (wr_ctrl_c || wr_speed_c)   cnt_q <= '0;
      else if (mode_q != MODE_HOLD)  cnt_q <= (cnt_q == speed_q) ? '0 : cnt_q + SPEED_W'(1);

      if (wr_pat_c)    led <= bus.HWDATA[LED_W-1:0];
      else if (tick_c) led <= led_next_c;

      if (wr_step_c)   step_q <= 16'd0;
      else if (tick_c) step_q <= step_q + 16'd1;
    end
  end

endmodule
